// File: rtl/led_breathe_if.sv
// LED drive stage port bundle: tick/mode in, PWM drive plus ramp-cycle strobe and level out.
interface led_breathe_if #(
   parameter int unsigned PWM_WIDTH = 8
);
   logic                 tick_i;
   logic [1:0]           mode_i;
   logic                 led_o;
   logic                 cycle_o;
   logic [PWM_WIDTH-1:0] level_o;

   modport master (output tick_i, mode_i, input led_o, cycle_o, level_o);
   modport slave  (input tick_i, mode_i, output led_o, cycle_o, level_o);
endinterface

// File: rtl/led_breathe.sv
// LED PWM driver with OFF/ON/BLINK/BREATHE patterns; level advances once per upstream tick.
// Optional LED_BREATHE_GAMMA_EN squares the level into the duty for a perceptual ramp.
module led_breathe #(
   parameter int unsigned PWM_WIDTH = 8,
   parameter int unsigned STEP      = 4,
   parameter int unsigned MIN_LEVEL = 0,
   parameter int unsigned MAX_LEVEL = 255
) (
   input  logic         clk_i,
   input  logic         rst_i,
   led_breathe_if.slave bus
);
   localparam int unsigned AW = PWM_WIDTH + 1;
   localparam logic [AW-1:0] MIN_E      = AW'(MIN_LEVEL);
   localparam logic [AW-1:0] MAX_E      = AW'(MAX_LEVEL);
   localparam logic [AW-1:0] STEP_E     = AW'(STEP);
   localparam logic [AW-1:0] MIN_STEP_E = AW'(MIN_LEVEL + STEP);
   localparam logic [PWM_WIDTH-1:0] MIN_L = PWM_WIDTH'(MIN_LEVEL);
   localparam logic [PWM_WIDTH-1:0] MAX_L = PWM_WIDTH'(MAX_LEVEL);

   localparam logic [1:0] M_OFF     = 2'b00;
   localparam logic [1:0] M_ON      = 2'b01;
   localparam logic [1:0] M_BLINK   = 2'b10;
   localparam logic [1:0] M_BREATHE = 2'b11;

   typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

   dir_t                 dir_q, dir_d;
   logic [PWM_WIDTH-1:0] level_q, level_d;
   logic [PWM_WIDTH-1:0] pwm_cnt;
   logic [PWM_WIDTH-1:0] duty;
   logic [1:0]           mode_q;
   logic                 cycle_q, cycle_d;
   logic                 led_q;
   logic [AW-1:0]        base, sum, diff;

   // State register: ramp direction, level, mode history, free-running PWM counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dir_q   <= UP;
         level_q <= MIN_L;
         mode_q  <= M_OFF;
         pwm_cnt <= '0;
         cycle_q <= 1'b0;
      end else begin
         dir_q   <= dir_d;
         level_q <= level_d;
         mode_q  <= bus.mode_i;
         pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
         cycle_q <= cycle_d;
      end
   end

   // Next-state: mode entry actions take priority over a same-cycle tick.
   always_comb begin
      level_d = level_q;
      dir_d   = dir_q;
      cycle_d = 1'b0;
      base    = (AW'(level_q) < MIN_E) ? MIN_E :
                ((AW'(level_q) > MAX_E) ? MAX_E : AW'(level_q));
      sum     = base + STEP_E;
      diff    = base - STEP_E;
      if (bus.mode_i != mode_q) begin
         if (bus.mode_i == M_BLINK) begin
            level_d = MAX_L;
         end else if (bus.mode_i == M_BREATHE) begin
            dir_d = UP;
         end
      end else if (bus.tick_i) begin
         case (mode_q)
            M_BLINK: level_d = (level_q == MIN_L) ? MAX_L : MIN_L;
            M_BREATHE: begin
               case (dir_q)
                  UP: begin
                     if (sum >= MAX_E) begin
                        level_d = MAX_L;
                        dir_d   = DOWN;
                     end else begin
                        level_d = PWM_WIDTH'(sum);
                     end
                  end
                  DOWN: begin
                     if (base < MIN_STEP_E) begin
                        level_d = MIN_L;
                        dir_d   = UP;
                        cycle_d = 1'b1;
                     end else begin
                        level_d = PWM_WIDTH'(diff);
                     end
                  end
                  default: dir_d = UP;
               endcase
            end
            default: ;
         endcase
      end
   end

`ifdef LED_BREATHE_GAMMA_EN
   logic [2*PWM_WIDTH-1:0] sq;
   logic [PWM_WIDTH-1:0]   duty_q;

   assign sq = (2*PWM_WIDTH)'(level_q) * (2*PWM_WIDTH)'(level_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) duty_q <= '0;
      else       duty_q <= PWM_WIDTH'(sq >> PWM_WIDTH);
   end

   assign duty = duty_q;
`else
   assign duty = level_q;
`endif

   // Registered LED drive.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         led_q <= 1'b0;
      end else begin
         case (mode_q)
            M_OFF:   led_q <= 1'b0;
            M_ON:    led_q <= 1'b1;
            default: led_q <= (pwm_cnt < duty);
         endcase
      end
   end

   assign bus.led_o   = led_q;
   assign bus.cycle_o = cycle_q;
   assign bus.level_o = level_q;
endmodule
